// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: FP register file, busy scoreboard and clear sequencer; FPRF_BYPASS_EN adds same-cycle write-to-read bypass
module fp_regfile_sb #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Clr_Req,
    input  logic              W_En,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] WR,
    input  logic              Iss_En,
    input  logic [ADDR_W-1:0] Iss_Addr,
    input  logic [ADDR_W-1:0] R_Addr,
    input  logic [ADDR_W-1:0] S_Addr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    output logic              R_Busy,
    output logic              S_Busy,
    output logic              Iss_Busy,
    output logic              Ready
);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [ADDR_W-1:0] idx;
    logic wr_ok, r_hit, s_hit;
    assign Ready = state == READY;
    assign wr_ok = Ready && W_En && !Clr_Req;
    always_comb begin
        state_nx = state;
        if (state == CLEAR && idx == ADDR_W'(DEPTH - 1))
            state_nx = READY;
        else if (state == READY && Clr_Req)
            state_nx = CLEAR;
    end
    always_ff @(posedge clk) begin
        state <= rst ? CLEAR : state_nx;
        if (rst) begin
            idx  <= '0;
            busy <= '0;
        end else if (!Ready) begin
            idx <= idx + 1'b1;
        end else if (Clr_Req) begin
            idx  <= '0;
            busy <= '0;
        end else begin
            if (W_En)
                busy[W_Addr] <= 1'b0;
            if (Iss_En)
                busy[Iss_Addr] <= 1'b1;
        end
    end
    // The array has no reset: the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!Ready)
                mem[idx] <= '0;
            else if (wr_ok)
                mem[W_Addr] <= WR;
        end
    end
`ifdef FPRF_BYPASS_EN
    assign r_hit = wr_ok && W_Addr == R_Addr;
    assign s_hit = wr_ok && W_Addr == S_Addr;
`else
    assign r_hit = 1'b0;
    assign s_hit = 1'b0;
`endif
    always_comb begin
        R        = !Ready ? '0 : r_hit ? WR : mem[R_Addr];
        S        = !Ready ? '0 : s_hit ? WR : mem[S_Addr];
        R_Busy   = Ready && !r_hit && busy[R_Addr];
        S_Busy   = Ready && !s_hit && busy[S_Addr];
        Iss_Busy = Ready && busy[Iss_Addr];
    end
endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb_fp_regfile_sb: directed and random checks of fp_regfile_sb against an array/counter model
module tb_fp_regfile_sb;
    localparam int DW = 64;
    localparam int N  = 32;
    localparam int AW = 5;
`ifdef FPRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Clr_Req = 1'b0, W_En = 1'b0, Iss_En = 1'b0;
    logic [AW-1:0] W_Addr = '0, Iss_Addr = '0, R_Addr = '0, S_Addr = '0;
    logic [DW-1:0] WR = '0;
    logic [DW-1:0] R, S;
    logic R_Busy, S_Busy, Iss_Busy, Ready;
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] m [N];
    bit b [N];
    int clr_left = N;
    int n;

    fp_regfile_sb #(.DATA_W(DW), .DEPTH(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .Clr_Req(Clr_Req), .W_En(W_En), .W_Addr(W_Addr), .WR(WR),
        .Iss_En(Iss_En), .Iss_Addr(Iss_Addr), .R_Addr(R_Addr), .S_Addr(S_Addr),
        .R(R), .S(S), .R_Busy(R_Busy), .S_Busy(S_Busy), .Iss_Busy(Iss_Busy), .Ready(Ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: clr_left counts edges of clearing still owed; the array is usable when it reaches 0.
    task automatic tick();
        if (rst) begin
            clr_left = N;
            foreach (b[i]) b[i] = 1'b0;
        end else if (clr_left > 0) begin
            m[N - clr_left] = '0;
            clr_left--;
        end else if (Clr_Req) begin
            clr_left = N;
            foreach (b[i]) b[i] = 1'b0;
        end else begin
            if (W_En) begin
                m[W_Addr] = WR;
                b[W_Addr] = 1'b0;
            end
            if (Iss_En) b[Iss_Addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string t);
        bit rdy, wv;
        rdy = clr_left == 0;
        wv  = BYP && rdy && W_En && !Clr_Req;
        chk({t, ".ready"}, 64'(Ready), 64'(rdy));
        chk({t, ".r"}, R, !rdy ? '0 : (wv && W_Addr == R_Addr) ? WR : m[R_Addr]);
        chk({t, ".s"}, S, !rdy ? '0 : (wv && W_Addr == S_Addr) ? WR : m[S_Addr]);
        chk({t, ".r_busy"}, 64'(R_Busy), 64'(rdy && !(wv && W_Addr == R_Addr) && b[R_Addr]));
        chk({t, ".s_busy"}, 64'(S_Busy), 64'(rdy && !(wv && W_Addr == S_Addr) && b[S_Addr]));
        chk({t, ".iss_busy"}, 64'(Iss_Busy), 64'(rdy && b[Iss_Addr]));
    endtask

    task automatic idle();
        W_En = 1'b0; Iss_En = 1'b0; Clr_Req = 1'b0;
    endtask

    task automatic wait_ready(input string t, input int exp_edges);
        n = 0;
        while (!Ready && n < 200) begin
            tick();
            n++;
        end
        chk(t, 64'(n), 64'(exp_edges));
    endtask

    initial begin
        #1;
        repeat (3) tick();
        check_all("reset");
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            W_En = 1'($urandom); Iss_En = 1'($urandom); Clr_Req = 1'($urandom);
            W_Addr = AW'($urandom); Iss_Addr = AW'($urandom); WR = {$urandom, $urandom};
            chk("clear_not_ready", 64'(Ready), 64'(0));
            tick();
        end
        idle();
        chk("clear_ready_after_32", 64'(Ready), 64'(1));
        for (int a = 0; a < N; a++) begin
            R_Addr = AW'(a); S_Addr = AW'(N - 1 - a); Iss_Addr = AW'(a);
            #1 check_all("cleared_entry");
        end
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        wait_ready("midclear_reset_edges", N);
        W_En = 1'b1; W_Addr = 5; WR = 64'h4009_21FB_5444_2D18;
        tick();
        idle(); R_Addr = 5; S_Addr = 5;
        #1;
        chk("wr_r", R, 64'h4009_21FB_5444_2D18);
        chk("wr_s", S, 64'h4009_21FB_5444_2D18);
        Iss_En = 1'b1; Iss_Addr = 7;
        tick();
        idle(); R_Addr = 7;
        #1;
        chk("iss_r_busy", 64'(R_Busy), 64'(1));
        chk("iss_busy", 64'(Iss_Busy), 64'(1));
        W_En = 1'b1; W_Addr = 7; WR = 64'h3ff0_0000_0000_0000;
        tick();
        idle();
        #1 chk("wr_clears_busy", 64'(R_Busy), 64'(0));
        W_En = 1'b1; Iss_En = 1'b1; W_Addr = 7; Iss_Addr = 7; WR = 64'hc000_0000_0000_0000;
        tick();
        idle();
        #1;
        chk("iss_wins_busy", 64'(R_Busy), 64'(1));
        chk("iss_wins_data", R, 64'hc000_0000_0000_0000);
        for (int i = 0; i < 400; i++) begin
            W_En = 1'($urandom); Iss_En = 1'($urandom_range(0, 2) == 0);
            Clr_Req = $urandom_range(0, 60) == 0;
            W_Addr = AW'($urandom_range(0, 7)); Iss_Addr = AW'($urandom_range(0, 7));
            R_Addr = AW'($urandom_range(0, 7)); S_Addr = AW'($urandom_range(0, 7));
            WR = {$urandom, $urandom};
            #1 check_all("random");
            tick();
        end
        idle();
        wait_ready("random_recover", clr_left);
        for (int a = 0; a < 4; a++) begin
            W_En = 1'b1; W_Addr = AW'(a); WR = 64'h1000 + 64'(a);
            tick();
        end
        W_En = 1'b0; Iss_En = 1'b1; Iss_Addr = 2;
        tick();
        Iss_En = 1'b0; Clr_Req = 1'b1; W_En = 1'b1; W_Addr = 0; WR = 64'hdead_beef;
        tick();
        idle();
        wait_ready("clr_req_edges", N);
        for (int a = 0; a < 4; a++) begin
            R_Addr = AW'(a); S_Addr = AW'(a); Iss_Addr = AW'(a);
            #1;
            chk("clr_data", R, 64'h0);
            chk("clr_busy", 64'(R_Busy), 64'(0));
            check_all("clr_model");
        end
        W_En = 1'b1; W_Addr = 9; WR = 64'h77; tick(); idle();
        W_En = 1'b1; W_Addr = 9; R_Addr = 9; S_Addr = 3; WR = 64'h1;
        #1;
        chk("bypass_same_cycle", R, BYP ? 64'h1 : 64'h77);
        check_all("bypass_model");
        tick();
        idle();
        #1 chk("bypass_next_cycle", R, 64'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
- Parametrised floating-point register file: DEPTH entries of DATA_W bits, one write port (W) and two read ports (R, S).
- Adds a per-register busy scoreboard, so issue logic can hold back instructions whose source or destination has a write pending from a multi-cycle FP unit.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request.
- Sits between FP issue/decode and the FP execution units.

Parameters:
- DATA_W, 64, width of each register and of WR/R/S.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, 5, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Clr_Req  in  1  one-cycle pulse; starts a full array clear (honoured only when Ready=1).
- W_En  in  1  write enable; the write completes the pending result for W_Addr.
- W_Addr  in  ADDR_W  write address.
- WR  in  DATA_W  write data.
- Iss_En  in  1  issue strobe; marks Iss_Addr busy.
- Iss_Addr  in  ADDR_W  destination register of the issued op.
- R_Addr  in  ADDR_W  read port R address.
- S_Addr  in  ADDR_W  read port S address.
- R  out  DATA_W  read data, port R.
- S  out  DATA_W  read data, port S.
- R_Busy  out  1  busy bit of R_Addr.
- S_Busy  out  1  busy bit of S_Addr.
- Iss_Busy  out  1  busy bit of Iss_Addr (WAW check).
- Ready  out  1  1 when the array is usable.

Behaviour:
- States: CLEAR, READY. Ready=1 iff state is READY.
- While rst=1 (at each edge): state<=CLEAR, clear index<=0, all busy bits<=0.
- Reset output values: Ready=0; R, S, R_Busy, S_Busy, Iss_Busy all 0.
- CLEAR, each edge with rst=0:
  - write 0 to entry[index] and increment index.
  - when index==DEPTH-1 is written, go to READY.
  - Ready therefore rises exactly DEPTH edges after the first edge with rst=0.
- In CLEAR:
  - W_En, Iss_En and Clr_Req are ignored.
  - R, S, R_Busy, S_Busy, Iss_Busy are forced to 0.
- rst asserted during CLEAR restarts the clear at index 0.
- READY + Clr_Req:
  - go to CLEAR with index=0 and clear all busy bits.
  - W_En/Iss_En on the same cycle are discarded.
- Write (READY, W_En=1): entry[W_Addr]<=WR and busy[W_Addr]<=0 at the edge.
- Issue (READY, Iss_En=1): busy[Iss_Addr]<=1 at the edge.
- Issue and write to the same address on the same edge: the issue wins, busy stays 1, and the data is still written.
- Issue and write to different addresses on the same edge: both take effect.
- Reads are combinational from the array (zero-latency, same as the previous-generation file).
- R_Busy, S_Busy and Iss_Busy are combinational lookups of the current busy bits; there is no bypass on the busy bits.
- R_Addr and S_Addr may be equal; both ports return the same value.
- No write-port arbitration: one write per cycle. Callers serialise writes.

Optional Feature:
- Macro: FPRF_BYPASS_EN.
- Defined:
  - if W_En=1 in READY and W_Addr==R_Addr, then R=WR and R_Busy=0 in the same cycle; S and S_Busy behave the same way.
  - A same-edge issue to that address does not affect the bypassed busy value.
- Undefined: reads return the pre-edge array contents, and busy reflects the pre-edge bit; the write is visible from the next cycle.

Test Plan:
- Reset + clear (DEPTH=32): rst high 3 cycles, then low → Ready=0 for 32 edges, rises after the 32nd; all 32 entries read 0; all busy bits 0.
- Reset mid-clear: drop rst, wait 10 edges, pulse rst 1 cycle, then release → Ready rises exactly 32 edges after the release.
- Write/read: W_En, W_Addr=5, WR=64'h4009_21FB_5444_2D18; next cycle R_Addr=5, S_Addr=5 → R=S=64'h4009_21FB_5444_2D18.
- Scoreboard:
  - Iss_En, Iss_Addr=7 → next cycle R_Addr=7 gives R_Busy=1 and Iss_Busy=1 for Iss_Addr=7.
  - W_En to 7 → busy clears the following cycle.
  - Issue and write to 7 on the same edge → busy stays 1.
- Clr_Req: fill regs 0–3 with nonzero data and set busy on 2, then pulse Clr_Req → Ready=0 for 32 edges; afterwards regs 0–3 read 0 and busy[2]=0; a W_En on the Clr_Req cycle has no effect.
- Bypass:
  - With FPRF_BYPASS_EN: W_En=1, W_Addr=R_Addr=9, WR=64'h1 → R=64'h1 in the same cycle.
  - Without it: R shows the old value in that cycle and 64'h1 in the next cycle.
